alu_sequencer: RTL

Single-clock instruction sequencer for the ALU/register/stack datapath of the x86-subset core. It accepts one opcode word per instruction from fetch and decodes ope[31:24]. It then steps the ALU through its phase-1/phase-2 updates and drives register write-back, stack-memory access and PC update. Its one-cycle enables replace the free-running phase clocks.

---
 rtl/alu_sequencer_if.sv | 33 +++
 rtl/alu_sequencer.sv | 129 ++++++++++++
 2 files changed

// File: rtl/alu_sequencer_if.sv
// Fetch, ALU, register and stack-memory signals of the ALU sequencer.
// The master side drives fetch and memory ack; the slave side is the sequencer itself.
interface alu_sequencer_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      ope;
    logic             ope_valid;
    logic             ope_ready;
    logic             mem_ack;
    logic [7:0]       alu_op;
    logic             alu_step1;
    logic             alu_step2;
    logic             reg_we;
    logic             mem_req;
    logic             mem_we;
    logic [2:0]       pc_inc;
    logic             pc_load;
    logic             busy;
    logic             illegal;
    logic [CNT_W-1:0] retired_count;

    modport master (
        output ope, ope_valid, mem_ack,
        input  ope_ready, alu_op, alu_step1, alu_step2, reg_we, mem_req, mem_we,
               pc_inc, pc_load, busy, illegal, retired_count
    );

    modport slave (
        input  ope, ope_valid, mem_ack,
        output ope_ready, alu_op, alu_step1, alu_step2, reg_we, mem_req, mem_we,
               pc_inc, pc_load, busy, illegal, retired_count
    );
endinterface

// File: rtl/alu_sequencer.sv
// One-instruction-in-flight sequencer: IDLE accept, DECODE, per-opcode S1/S2/MEM/WB steps, RETIRE.
// Latency 4-6 cycles accept-to-IDLE plus MEM wait; fetch is stalled (ope_ready=0) whenever not IDLE.
module alu_sequencer #(
    parameter int CNT_W           = 16,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic           clock,
    input  logic           reset_n,
    alu_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_S1, S_S2, S_MEM, S_WB, S_RETIRE, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        CL_MOV, CL_MOVI, CL_PUSH, CL_CALL, CL_POP, CL_RET, CL_ILL
    } class_t;

    state_t           state_q, state_d;
    class_t           cls;
    logic [2:0]       len;
    logic             is_write, is_jump;

    logic [7:0]       alu_op_q;
    logic             step1_q, step2_q, reg_we_q, mem_req_q, mem_we_q, pc_load_q;
    logic [2:0]       pc_inc_q;
    logic             ready_q, busy_q, illegal_q;
    logic [CNT_W-1:0] cnt_q;

    // Only the opcode byte matters; the operand bytes belong to the datapath.
    logic unused_ope;
    assign unused_ope = ^bus.ope[23:0];

    always_comb begin
        cls = CL_ILL;
        len = 3'd1;
        case (alu_op_q)
            8'h89: begin cls = CL_MOV;  len = 3'd2; end
            8'hb8: begin cls = CL_MOVI; len = 3'd5; end
            8'h55: begin cls = CL_PUSH; len = 3'd1; end
            8'he8: begin cls = CL_CALL; len = 3'd5; end
            8'h5d: begin cls = CL_POP;  len = 3'd1; end
            8'hc3: begin cls = CL_RET;  len = 3'd1; end
            default: begin cls = CL_ILL; len = 3'd1; end
        endcase
    end

    assign is_write = (cls == CL_PUSH) || (cls == CL_CALL);
    assign is_jump  = (cls == CL_CALL) || (cls == CL_RET);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (bus.ope_valid) state_d = S_DECODE;
            S_DECODE: begin
                if (cls == CL_ILL) state_d = HALT_ON_ILLEGAL ? S_HALT : S_RETIRE;
                else               state_d = S_S1;
            end
            S_S1: begin
                case (cls)
                    CL_MOV:          state_d = S_WB;
                    CL_POP, CL_RET:  state_d = S_MEM;
                    default:         state_d = S_S2;
                endcase
            end
            S_S2: begin
                case (cls)
                    CL_PUSH, CL_CALL: state_d = S_MEM;
                    CL_RET:           state_d = S_RETIRE;
                    default:          state_d = S_WB;
                endcase
            end
            // Push/call finish with the write; pop/ret still need S2 after the read.
            S_MEM:    if (bus.mem_ack) state_d = is_write ? S_RETIRE : S_S2;
            S_WB:     state_d = S_RETIRE;
            S_RETIRE: state_d = S_IDLE;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so each strobe lines up with its state cycle.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            alu_op_q  <= 8'h00;
            step1_q   <= 1'b0;
            step2_q   <= 1'b0;
            reg_we_q  <= 1'b0;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            pc_load_q <= 1'b0;
            pc_inc_q  <= 3'd0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && bus.ope_valid) alu_op_q <= bus.ope[31:24];
            if (state_q == S_DECODE && cls == CL_ILL) illegal_q <= 1'b1;
            if (state_q == S_RETIRE) cnt_q <= cnt_q + CNT_W'(1);
            step1_q   <= (state_d == S_S1);
            step2_q   <= (state_d == S_S2);
            reg_we_q  <= (state_d == S_WB);
            mem_req_q <= (state_d == S_MEM);
            mem_we_q  <= (state_d == S_MEM) && is_write;
            pc_load_q <= (state_d == S_RETIRE) && is_jump;
            pc_inc_q  <= (state_d == S_RETIRE && !is_jump) ? len : 3'd0;
            ready_q   <= (state_d == S_IDLE);
            busy_q    <= (state_d != S_IDLE);
        end
    end

    assign bus.ope_ready     = ready_q;
    assign bus.alu_op        = alu_op_q;
    assign bus.alu_step1     = step1_q;
    assign bus.alu_step2     = step2_q;
    assign bus.reg_we        = reg_we_q;
    assign bus.mem_req       = mem_req_q;
    assign bus.mem_we        = mem_we_q;
    assign bus.pc_inc        = pc_inc_q;
    assign bus.pc_load       = pc_load_q;
    assign bus.busy          = busy_q;
    assign bus.illegal       = illegal_q;
    assign bus.retired_count = cnt_q;

endmodule
